mem_stage_fsm: RTL and testbench
================================

MEM_STAGE_FSM -- requirements
Module: mem_stage_fsm

Interface
REQ-001 Parameter RAW, default 5: register-file address width.
REQ-002 Parameter AW, default 32: data-bus byte address width; data width fixed at 32.
REQ-003 Parameter TMO, default 15, range 1..255: maximum bus wait cycles before timeout.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  EX/MEM holds an instruction.
REQ-007 in_ready  out  1  stage accepts the instruction this cycle.
REQ-008 memop_i  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW, others=none.
REQ-009 maddr_i  in  AW  effective address; sdata_i  in  32  store data.
REQ-010 waddr_i  in  RAW, we_i  in  1, wdata_i  in  32: GPR write request.
REQ-011 whilo_i  in  1, hi_i  in  32, lo_i  in  32: HI/LO write request.
REQ-012 mem_req  out  1, mem_we  out  1, mem_sel  out  4, mem_addr  out  AW, mem_wdata  out  32: bus request.
REQ-013 mem_rdata  in  32, mem_ack  in  1: bus response, rdata valid when ack=1.
REQ-014 out_valid  out  1: MEM/WB outputs valid, one-cycle pulse.
REQ-015 waddr_o  out  RAW, we_o  out  1, wdata_o  out  32, whilo_o  out  1, hi_o  out  32, lo_o  out  32, err_o  out  1: registered results.

Function
REQ-016 FSM states IDLE, BUS; in_ready=1 only in IDLE; transfer = in_valid & in_ready.
REQ-017 Non-memory transfer: outputs register inputs unchanged at next edge, out_valid=1 for one cycle, stay IDLE.
REQ-018 Memory transfer: latch op/address/data, go to BUS; mem_req=1 from the following cycle until ack or timeout.
REQ-019 Bus fields stable while mem_req=1; mem_addr = maddr_i with bits [1:0] zeroed; mem_we=1 for SB/SH/SW.
REQ-020 Big-endian lanes: byte offset 0 -> sel 1000 and bits 31:24; half offset 0 -> sel 1100; word -> sel 1111.
REQ-021 Store data replicated: SB {4{b}}, SH {2{h}}, SW as-is.
REQ-022 Load: selected lane sign-extended (LB/LH) or zero-extended (LBU/LHU) into wdata_o; stores pass wdata_i, we_i.
REQ-023 On mem_ack in BUS: mem_req=0 at next edge, results + out_valid=1 registered at same edge, return IDLE.
REQ-024 Wait counter 8-bit, cleared on entry to BUS, increments each BUS cycle without ack.
REQ-025 Counter reaching TMO without ack: drop mem_req, out_valid=1, err_o=1, we_o=0, whilo_o=0, return IDLE.
REQ-026 Ack on the same cycle the counter reaches TMO: ack wins, err_o=0.
REQ-027 mem_ack while mem_req=0: ignored.
REQ-028 out_valid=0 cycles: all other outputs hold last values.

Reset
REQ-029 rst=1: state IDLE, counter 0, mem_req=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, all *_o=0, out_valid=0, err_o=0.
REQ-030 rst during BUS: transaction abandoned, mem_req=0 after that edge, no out_valid produced.

Configuration
REQ-031 Macro MEM_ALIGN_CHK_EN defined: LH/LHU/SH with maddr_i[0]=1, or LW/SW with maddr_i[1:0]!=0, issue no bus request; out_valid+err_o=1, we_o=0 next edge.
REQ-032 Macro undefined: misaligned low address bits ignored (forced to natural alignment); access proceeds, err_o only from timeout.

Verification
REQ-033 Non-memory op, we_i=1, waddr_i=3, wdata_i=0x1234 -> next cycle out_valid=1, waddr_o=3, wdata_o=0x1234, mem_req never 1.
REQ-034 LB addr 0x101, ack after 2 wait cycles, rdata 0x11F0_2233 -> sel 0100, wdata_o=0xFFFF_FFF0; LBU -> 0x0000_00F0.
REQ-035 SH addr 0x102, sdata 0xAAAA_BEEF -> mem_we=1, sel 0011, mem_wdata=0xBEEF_BEEF, mem_addr=0x100.
REQ-036 LW with no ack, TMO=15 -> mem_req high 15 cycles then drops, out_valid=1, err_o=1, we_o=0.
REQ-037 rst asserted second BUS cycle -> mem_req=0 next cycle, out_valid stays 0, in_ready=1.
REQ-038 MEM_ALIGN_CHK_EN defined, LW addr 0x102 -> no mem_req, out_valid=1, err_o=1; undefined -> mem_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_stage_fsm.sv
// rtl/mem_stage_fsm.sv - MEM pipeline stage: big-endian data bus access with timeout, GPR/HILO passthrough
// Optional misalignment trap: define MEM_ALIGN_CHK_EN.
module mem_stage_fsm #(
    parameter int RAW = 5,
    parameter int AW  = 32,
    parameter int TMO = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     memop_i,
    input  logic [AW-1:0]  maddr_i,
    input  logic [31:0]    sdata_i,
    input  logic [RAW-1:0] waddr_i,
    input  logic           we_i,
    input  logic [31:0]    wdata_i,
    input  logic           whilo_i,
    input  logic [31:0]    hi_i,
    input  logic [31:0]    lo_i,
    output logic           mem_req,
    output logic           mem_we,
    output logic [3:0]     mem_sel,
    output logic [AW-1:0]  mem_addr,
    output logic [31:0]    mem_wdata,
    input  logic [31:0]    mem_rdata,
    input  logic           mem_ack,
    output logic           out_valid,
    output logic [RAW-1:0] waddr_o,
    output logic           we_o,
    output logic [31:0]    wdata_o,
    output logic           whilo_o,
    output logic [31:0]    hi_o,
    output logic [31:0]    lo_o,
    output logic           err_o
);
    typedef enum logic [0:0] {S_IDLE, S_BUS} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t         state;
    logic [7:0]     wait_cnt;
    logic [3:0]     op_q;
    logic [1:0]     off_q;
    logic [RAW-1:0] waddr_q;
    logic           we_q;
    logic [31:0]    wdata_q;
    logic           whilo_q;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;

    logic           is_mem, is_store, is_byte, is_half;
    logic [1:0]     off_n;
    logic [3:0]     sel_n;
    logic [31:0]    wd_rep;
    logic           align_err;
    logic [7:0]     byte_v;
    logic [15:0]    half_v;
    logic [31:0]    load_data;

    assign in_ready = (state == S_IDLE);

    always_comb begin
        is_mem   = (memop_i >= 4'd1) && (memop_i <= 4'd8);
        is_store = (memop_i >= 4'd6) && (memop_i <= 4'd8);
        is_byte  = (memop_i == 4'd1) || (memop_i == 4'd2) || (memop_i == 4'd6);
        is_half  = (memop_i == 4'd3) || (memop_i == 4'd4) || (memop_i == 4'd7);
        // Low address bits beyond the access size are dropped, giving natural alignment.
        if (is_byte) begin
            off_n  = maddr_i[1:0];
            sel_n  = 4'b1000 >> off_n;
            wd_rep = {4{sdata_i[7:0]}};
        end else if (is_half) begin
            off_n  = {maddr_i[1], 1'b0};
            sel_n  = 4'b1100 >> off_n;
            wd_rep = {2{sdata_i[15:0]}};
        end else begin
            off_n  = 2'b00;
            sel_n  = 4'b1111;
            wd_rep = sdata_i;
        end
`ifdef MEM_ALIGN_CHK_EN
        align_err = (is_half && maddr_i[0]) ||
                    (is_mem && !is_byte && !is_half && (maddr_i[1:0] != 2'b00));
`else
        align_err = 1'b0;
`endif
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_v = mem_rdata[31:24];
            2'd1:    byte_v = mem_rdata[23:16];
            2'd2:    byte_v = mem_rdata[15:8];
            default: byte_v = mem_rdata[7:0];
        endcase
        half_v = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (op_q)
            4'd1:    load_data = {{24{byte_v[7]}}, byte_v};
            4'd2:    load_data = {24'd0, byte_v};
            4'd3:    load_data = {{16{half_v[15]}}, half_v};
            4'd4:    load_data = {16'd0, half_v};
            4'd5:    load_data = mem_rdata;
            default: load_data = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            op_q      <= 4'd0;
            off_q     <= 2'd0;
            waddr_q   <= '0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            whilo_q   <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            out_valid <= 1'b0;
            waddr_o   <= '0;
            we_o      <= 1'b0;
            wdata_o   <= 32'd0;
            whilo_o   <= 1'b0;
            hi_o      <= 32'd0;
            lo_o      <= 32'd0;
            err_o     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!is_mem || align_err) begin
                            out_valid <= 1'b1;
                            waddr_o   <= waddr_i;
                            we_o      <= we_i && !align_err;
                            wdata_o   <= wdata_i;
                            whilo_o   <= whilo_i && !align_err;
                            hi_o      <= hi_i;
                            lo_o      <= lo_i;
                            err_o     <= align_err;
                        end else begin
                            state     <= S_BUS;
                            wait_cnt  <= 8'd0;
                            op_q      <= memop_i;
                            off_q     <= off_n;
                            waddr_q   <= waddr_i;
                            we_q      <= we_i;
                            wdata_q   <= wdata_i;
                            whilo_q   <= whilo_i;
                            hi_q      <= hi_i;
                            lo_q      <= lo_i;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_sel   <= sel_n;
                            mem_addr  <= {maddr_i[AW-1:2], 2'b00};
                            mem_wdata <= wd_rep;
                        end
                    end
                end
                S_BUS: begin
                    // Ack takes priority over the timeout on the final wait cycle.
                    if (mem_ack || wait_cnt == TMO_LAST) begin
                        state     <= S_IDLE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        waddr_o   <= waddr_q;
                        we_o      <= we_q && mem_ack;
                        wdata_o   <= mem_ack ? load_data : wdata_q;
                        whilo_o   <= whilo_q && mem_ack;
                        hi_o      <= hi_q;
                        lo_o      <= lo_q;
                        err_o     <= !mem_ack;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_fsm.sv
// tb/tb_mem_stage_fsm.sv - vector table plus scoreboard bench for mem_stage_fsm
module tb_mem_stage_fsm;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  memop_i;
    logic [31:0] maddr_i, sdata_i, wdata_i, hi_i, lo_i;
    logic [4:0]  waddr_i;
    logic        we_i, whilo_i;
    logic        mem_req, mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic [4:0]  waddr_o;
    logic        we_o, whilo_o, err_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    mem_stage_fsm #(.RAW(5), .AW(32), .TMO(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .memop_i(memop_i), .maddr_i(maddr_i), .sdata_i(sdata_i),
        .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .out_valid(out_valid),
        .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, sdata, wdata, hi, lo, rdata;
        logic [4:0]  waddr;
        logic        we, whilo;
        int          dly;
        int          e_req;
        logic [3:0]  e_sel;
        logic [31:0] e_mwd, e_wd;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [4:0]  waddr;
        logic        we, whilo, err;
        logic [31:0] wdata, hi, lo;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] wdata, input logic we, input int dly,
                                input logic [31:0] rdata, input int e_req, input logic [3:0] e_sel,
                                input logic [31:0] e_mwd, input logic [31:0] e_wd, input logic e_err);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.wdata = wdata; v.we = we;
        v.dly = dly; v.rdata = rdata; v.e_req = e_req; v.e_sel = e_sel;
        v.e_mwd = e_mwd; v.e_wd = e_wd; v.e_err = e_err;
        v.waddr = 5'd0; v.whilo = 1'b0; v.hi = 32'd0; v.lo = 32'd0;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("waddr_o", 32'(waddr_o), 32'(e.waddr));
                chk("we_o", 32'(we_o), 32'(e.we));
                chk("wdata_o", wdata_o, e.wdata);
                chk("whilo_o", 32'(whilo_o), 32'(e.whilo));
                chk("hi_o", hi_o, e.hi);
                chk("lo_o", lo_o, e.lo);
                chk("err_o", 32'(err_o), 32'(e.err));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   req_cycles;
        logic is_store;
        is_store = (v.op >= 4'd6) && (v.op <= 4'd8);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; memop_i = v.op; maddr_i = v.addr; sdata_i = v.sdata;
        waddr_i = v.waddr; we_i = v.we; wdata_i = v.wdata;
        whilo_i = v.whilo; hi_i = v.hi; lo_i = v.lo;
        e.waddr = v.waddr; e.we = v.we && !v.e_err; e.whilo = v.whilo && !v.e_err;
        e.err = v.e_err; e.wdata = v.e_wd; e.hi = v.hi; e.lo = v.lo;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0; memop_i = 4'd0;
        req_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!mem_req) break;
            chk("mem_sel", 32'(mem_sel), 32'(v.e_sel));
            chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
            chk("mem_we", 32'(mem_we), 32'(is_store));
            if (is_store) chk("mem_wdata", mem_wdata, v.e_mwd);
            req_cycles++;
            if (req_cycles == v.dly + 1) begin
                mem_ack = 1'b1;
                mem_rdata = v.rdata;
            end
            @(posedge clk);
            #1 mem_ack = 1'b0;
            mem_rdata = 32'hDEAD_DEAD;
        end
        chk("req_cycles", 32'(req_cycles), 32'(v.e_req));
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("out_valid_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        vecs[0]  = mk(4'd0, 32'h0,   32'h0,        32'h1234, 1'b1, 0,   32'h0,        0,  4'b0000, 32'h0,        32'h1234,     1'b0);
        vecs[1]  = mk(4'd9, 32'h44,  32'h0,        32'h55,   1'b0, 0,   32'h0,        0,  4'b0000, 32'h0,        32'h55,       1'b0);
        vecs[2]  = mk(4'd1, 32'h101, 32'h0,        32'h9,    1'b1, 2,   32'h11F02233, 3,  4'b0100, 32'h0,        32'hFFFFFFF0, 1'b0);
        vecs[3]  = mk(4'd2, 32'h101, 32'h0,        32'h9,    1'b1, 2,   32'h11F02233, 3,  4'b0100, 32'h0,        32'h000000F0, 1'b0);
        vecs[4]  = mk(4'd7, 32'h102, 32'hAAAABEEF, 32'h77,   1'b0, 0,   32'h0,        1,  4'b0011, 32'hBEEFBEEF, 32'h77,       1'b0);
        vecs[5]  = mk(4'd3, 32'h002, 32'h0,        32'h0,    1'b1, 1,   32'h12348001, 2,  4'b0011, 32'h0,        32'hFFFF8001, 1'b0);
        vecs[6]  = mk(4'd4, 32'h200, 32'h0,        32'h0,    1'b1, 0,   32'h80010000, 1,  4'b1100, 32'h0,        32'h00008001, 1'b0);
        vecs[7]  = mk(4'd5, 32'h10,  32'h0,        32'h0,    1'b1, 0,   32'hCAFEF00D, 1,  4'b1111, 32'h0,        32'hCAFEF00D, 1'b0);
        vecs[8]  = mk(4'd6, 32'h103, 32'h123456A5, 32'h3,    1'b1, 4,   32'h0,        5,  4'b0001, 32'hA5A5A5A5, 32'h3,        1'b0);
        vecs[9]  = mk(4'd8, 32'h8,   32'h01020304, 32'h4,    1'b1, 0,   32'h0,        1,  4'b1111, 32'h01020304, 32'h4,        1'b0);
        vecs[10] = mk(4'd5, 32'h20,  32'h0,        32'hABCD, 1'b1, 255, 32'h0,        15, 4'b1111, 32'h0,        32'hABCD,     1'b1);
        vecs[11] = mk(4'd1, 32'h44,  32'h0,        32'h0,    1'b1, 14,  32'h7F000000, 15, 4'b1000, 32'h0,        32'h7F,       1'b0);
`ifdef MEM_ALIGN_CHK_EN
        vecs[12] = mk(4'd5, 32'h102, 32'h0,        32'h66,   1'b1, 0,   32'h89ABCDEF, 0,  4'b0000, 32'h0,        32'h66,       1'b1);
`else
        vecs[12] = mk(4'd5, 32'h102, 32'h0,        32'h66,   1'b1, 0,   32'h89ABCDEF, 1,  4'b1111, 32'h0,        32'h89ABCDEF, 1'b0);
`endif
        for (int i = 0; i < 13; i++) begin
            vecs[i].waddr = 5'(i + 3);
            vecs[i].whilo = i[0];
            vecs[i].hi    = 32'h1000_0000 + 32'(i);
            vecs[i].lo    = 32'h2000_0000 + 32'(i * 7);
        end

        rst = 1'b1; in_valid = 1'b0; memop_i = 4'd0; maddr_i = 32'd0; sdata_i = 32'd0;
        waddr_i = 5'd0; we_i = 1'b0; wdata_i = 32'd0; whilo_i = 1'b0; hi_i = 32'd0; lo_i = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_sel", 32'(mem_sel), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wdata_o", wdata_o, 32'd0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Outputs hold after the pulse; stray acks in IDLE do nothing.
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ack_req", 32'(mem_req), 32'd0);
            chk("hold_wdata_o", wdata_o, vecs[12].e_wd);
            chk("hold_err_o", 32'(err_o), 32'(vecs[12].e_err));
        end
        mem_ack = 1'b0;

        // Reset in the second BUS cycle abandons the access.
        @(negedge clk);
        in_valid = 1'b1; memop_i = 4'd5; maddr_i = 32'h40; we_i = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; memop_i = 4'd0;
        @(negedge clk);
        chk("bus1_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("bus2_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bus_req", 32'(mem_req), 32'd0);
        chk("rst_bus_in_ready", 32'(in_ready), 32'd1);
        chk("rst_bus_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);

        run_vec(vecs[7]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
